// File: rtl/x9_pkg.sv
// Shared types and default sizing for the X9 run controller.
package x9_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD   = 2'd1,
    RUN    = 2'd2,
    REPORT = 2'd3
  } run_state_t;

  localparam int X9_CYC_W   = 16;
  localparam int X9_RST_CYC = 2;
  localparam int X9_TIMEOUT = 4000;

endpackage

// File: rtl/x9_run_ctrl_run_cycle_ctr.sv
// Purpose: CW-bit up-counter with sync clear, enable, saturation at all-ones, terminal count at TC_VAL.
// Latency: count updates one cycle after en; tc is a decode of the current count.
// Backpressure: none, the counter simply holds when en is low or it is saturated.
module run_cycle_ctr #(
  parameter int             CW     = 16,
  parameter logic [CW-1:0]  TC_VAL = '1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr,
  input  logic          en,
  output logic [CW-1:0] cnt,
  output logic          tc
);

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      cnt <= '0;
    end else if (en && (cnt != '1)) begin
      cnt <= cnt + CW'(1);
    end
  end

  assign tc = (cnt == TC_VAL);

endmodule

// File: rtl/x9_run_ctrl.sv
// Purpose: owns the X9 core reset; holds it RST_CYC cycles, runs until done/limit, reports. Macro X9_RUN_CTRL_TIMEOUT_EN enables the limit.
// Latency: req to ack is RST_CYC + k + 1 cycles for done in RUN cycle k; all outputs registered.
// Backpressure: req is a level sampled only in IDLE; core_done is sampled only in RUN.
module x9_run_ctrl
  import x9_pkg::*;
#(
  parameter int CW      = X9_CYC_W,
  parameter int RST_CYC = X9_RST_CYC,
  parameter int TIMEOUT = X9_TIMEOUT
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req,
  input  logic          core_done,
  output logic          core_reset,
  output logic          busy,
  output logic          ack,
  output logic [CW-1:0] cycles,
  output logic          timeout
);

  localparam int HW = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;

  run_state_t    state_q, state_d;
  logic [HW-1:0] hold_q;
  logic          ctr_clr, ctr_en;
  logic          run_tc;
  logic          limit_hit;

  run_cycle_ctr #(
    .CW     (CW),
    .TC_VAL (CW'(TIMEOUT - 1))
  ) u_run_ctr (
    .clk   (clk),
    .reset (reset),
    .clr   (ctr_clr),
    .en    (ctr_en),
    .cnt   (cycles),
    .tc    (run_tc)
  );

`ifdef X9_RUN_CTRL_TIMEOUT_EN
  // tc is true during RUN cycle TIMEOUT, so the count lands on TIMEOUT at the edge
  assign limit_hit = run_tc;

  always_ff @(posedge clk) begin
    if (reset || ctr_clr) begin
      timeout <= 1'b0;
    end else if ((state_q == RUN) && run_tc && !core_done) begin
      timeout <= 1'b1;
    end
  end
`else
  logic tc_unused;
  assign tc_unused = run_tc;
  assign limit_hit = 1'b0;
  assign timeout   = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      hold_q     <= '0;
      core_reset <= 1'b1;
      busy       <= 1'b0;
      ack        <= 1'b0;
    end else begin
      state_q    <= state_d;
      if (state_q == IDLE) begin
        hold_q <= HW'(RST_CYC - 1);
      end else if ((state_q == HOLD) && (hold_q != '0)) begin
        hold_q <= hold_q - HW'(1);
      end
      core_reset <= (state_d != RUN);
      busy       <= (state_d == HOLD) || (state_d == RUN);
      ack        <= (state_d == REPORT);
    end
  end

  always_comb begin
    state_d = state_q;
    ctr_clr = 1'b0;
    ctr_en  = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          state_d = HOLD;
          ctr_clr = 1'b1;
        end
      end
      HOLD: begin
        if (hold_q == '0) state_d = RUN;
      end
      RUN: begin
        ctr_en = 1'b1;
        if (core_done || limit_hit) state_d = REPORT;
      end
      REPORT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: doc/x9_run_ctrl.md
# x9_run_ctrl

Run controller that sits directly upstream of the X9 core top level. On a start request it holds the core in synchronous reset for a fixed number of cycles, releases it, and counts execution cycles until the core raises `done` or a cycle limit expires. It then returns the core to reset and reports the result with a one-cycle acknowledge. It is the block that owns the core's `reset` input and consumes its `done` output; testbenches and any future multi-program sequencer talk only to this block.

## Interface
Parameters:
- `CW`, 16: cycle counter width.
- `RST_CYC`, 2: number of cycles the core is held in reset before running; legal range is 1 or more.
- `TIMEOUT`, 4000: maximum number of RUN cycles before the run is aborted; legal range is 1 to 2^CW-1.

Ports:
- `clk`  in  1: the single clock; all state changes on its rising edge.
- `reset`  in  1: synchronous, active-high reset.
- `req`  in  1: start request; a level, sampled only in IDLE.
- `core_done`  in  1: the core's `done` output; sampled only in RUN.
- `core_reset`  out  1: drives the core's `reset` input.
- `busy`  out  1: high in HOLD and RUN.
- `ack`  out  1: one-cycle pulse marking run completion.
- `cycles`  out  CW: RUN-cycle count for the last run.
- `timeout`  out  1: the last run ended on the cycle limit.

## Operation
- States are IDLE, HOLD, RUN and REPORT; the reset state is IDLE.
- Output values by state:
  - IDLE: `core_reset`=1, `busy`=0, `ack`=0.
  - HOLD: `core_reset`=1, `busy`=1.
  - RUN: `core_reset`=0, `busy`=1.
  - REPORT: `core_reset`=1, `busy`=0, `ack`=1.
- Reset values: `core_reset`=1, `busy`=0, `ack`=0, `cycles`=0, `timeout`=0.
- IDLE goes to HOLD when `req`=1. On that transition `cycles` and `timeout` clear to 0 and the hold counter loads.
- HOLD lasts exactly `RST_CYC` cycles, then goes to RUN.
- RUN increments `cycles` by 1 every cycle, so `cycles`=k during the k-th RUN cycle after its edge.
  - If `core_done`=1 during RUN cycle k: `cycles` is written to k and the next state is REPORT with `timeout`=0.
  - Timeout: if RUN cycle k=`TIMEOUT` ends with `core_done`=0, the next state is REPORT with `timeout`=1 and `cycles`=`TIMEOUT`.
  - If `core_done` and the timeout condition occur in the same cycle, done wins and `timeout`=0.
- REPORT lasts one cycle, then goes to IDLE.
- `cycles` and `timeout` hold their values until the next IDLE-to-HOLD transition.
- `req` is ignored outside IDLE. If `req` is held high, a new run starts in the cycle after REPORT.
- `core_done` is ignored in IDLE, HOLD and REPORT. This masks the core's combinational `done` while the core is in reset.
- Widths: `cycles` is unsigned and never wraps; it is bounded by `TIMEOUT`, or saturates as described under Configuration.

## Timing
- Take the cycle in which IDLE samples `req`=1 as cycle 0:
  - HOLD occupies cycles 1 to `RST_CYC`.
  - The first RUN cycle is `RST_CYC`+1.
- If done is seen in RUN cycle k, `ack` is high in cycle `RST_CYC`+k+1. Latency from `req` to `ack` is therefore `RST_CYC`+k+1 cycles.
- The core sees `core_reset`=1 in at least `RST_CYC` consecutive cycles immediately before RUN, which guarantees a synchronous reset edge.
- Asserting `reset` at any point, including mid-RUN: the next cycle is IDLE with reset values, no `ack` is issued, and `core_reset`=1.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- Macro: `X9_RUN_CTRL_TIMEOUT_EN`.
- Defined: the cycle limit works as specified under Operation.
- Undefined:
  - RUN waits indefinitely for `core_done`.
  - `timeout` is constant 0.
  - `cycles` saturates at 2^CW-1 and does not increment further.
  - `TIMEOUT` is unused.

## Structure
- Shared package `x9_pkg` holds:
  - enum `run_state_t` (IDLE, HOLD, RUN, REPORT);
  - default constants `X9_CYC_W`=16, `X9_RST_CYC`=2, `X9_TIMEOUT`=4000.
- One natural sub-module, `run_cycle_ctr`: a CW-bit counter with synchronous clear, enable, saturation and terminal-count output. It is used once for the run count; the HOLD down-counter is inline.

## Test plan
All scenarios use `RST_CYC`=2, `TIMEOUT`=20, `CW`=16.
- Hold `reset`=1 for 3 cycles → `core_reset`=1, `busy`=0, `ack`=0, `cycles`=0, `timeout`=0.
- `req` pulse in cycle 0, `core_done`=1 in cycle 8 → `core_reset`=0 only in cycles 3 to 8, `ack` in cycle 9, `cycles`=6, `timeout`=0.
- `req` pulse, `core_done` never asserted → `ack` in cycle 23, `cycles`=20, `timeout`=1, `core_reset`=1 from cycle 23 onward.
- `core_done`=1 exactly in RUN cycle 20 → `ack` in cycle 23, `cycles`=20, `timeout`=0.
- `req` held high through two runs, each ending on `core_done` in RUN cycle 1:
  - first `ack` in cycle 4, IDLE in cycle 5;
  - second HOLD starts in cycle 6, second `ack` in cycle 9.
  - Pulsing `req` during RUN has no effect.
- `reset` asserted in RUN cycle 5 → IDLE in the next cycle, no `ack` in any cycle, `busy`=0, `cycles`=0. With `X9_RUN_CTRL_TIMEOUT_EN` undefined and no `core_done` for 100 RUN cycles → `busy`=1, `cycles`=100, `timeout`=0.
